// File: rtl/vram_fill_dma.sv
// Block-fill DMA for the character / fg colour / bg colour video RAMs, sharing port A with the CPU (CPU has priority).
// Optional build macro VRAM_FILL_VBLANK_ONLY_EN restricts fill writes to vertical blank.
module vram_fill_dma #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned LEN_W  = 12,
  parameter int unsigned NTGT   = 3
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              reg_cs,
  input  logic              reg_wr,
  input  logic [2:0]        reg_addr,
  input  logic [7:0]        reg_din,
  output logic [7:0]        reg_dout,
  input  logic [ADDR_W-1:0] cpu_ram_addr,
  input  logic [7:0]        cpu_ram_data,
  input  logic [NTGT-1:0]   cpu_ram_wr,
  input  logic              vblank,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic [NTGT-1:0]   ram_wr,
  output logic              busy,
  output logic              done_pulse
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] start_r, cur_addr;
  logic [LEN_W-1:0]  len_r, remaining;
  logic [7:0]        fill_r, cur_fill;
  logic [NTGT-1:0]   tgt_r, cur_tgt;
  logic              done_r, aborted_r, done_pulse_r;

  logic reg_we_c, ctrl_we_c, start_req_c, abort_req_c, empty_c;
  logic slot_ok_c, dma_wr_c, last_c;

  assign reg_we_c    = reg_cs & reg_wr;
  assign ctrl_we_c   = reg_we_c && (reg_addr == 3'd6);
  assign abort_req_c = ctrl_we_c & reg_din[1];
  assign start_req_c = ctrl_we_c & reg_din[0] & ~reg_din[1];
  assign empty_c     = (len_r == '0) || (tgt_r == '0);

`ifdef VRAM_FILL_VBLANK_ONLY_EN
  assign slot_ok_c = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign slot_ok_c     = 1'b1;
`endif

  // A fill write only takes a slot the CPU is not using this cycle
  assign dma_wr_c = (state == S_RUN) && (cpu_ram_wr == '0) && slot_ok_c;
  assign last_c   = dma_wr_c && (remaining == LEN_W'(1));

  assign busy       = (state == S_RUN);
  assign done_pulse = done_pulse_r;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_req_c && !empty_c) state_nxt = S_RUN;
      S_RUN:  if (abort_req_c || last_c)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ram_addr = cpu_ram_addr;
    ram_data = cpu_ram_data;
    ram_wr   = cpu_ram_wr;
    if (dma_wr_c) begin
      ram_addr = cur_addr;
      ram_data = cur_fill;
      ram_wr   = cur_tgt;
    end
  end

  // Register file plus working copies latched at start so mid-fill register writes are harmless
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      start_r      <= '0;
      len_r        <= '0;
      fill_r       <= '0;
      tgt_r        <= '0;
      cur_addr     <= '0;
      remaining    <= '0;
      cur_fill     <= '0;
      cur_tgt      <= '0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
      done_pulse_r <= 1'b0;
    end else begin
      done_pulse_r <= 1'b0;
      if (reg_we_c) begin
        case (reg_addr)
          3'd0: start_r[7:0]        <= reg_din;
          3'd1: start_r[ADDR_W-1:8] <= reg_din[ADDR_W-9:0];
          3'd2: len_r[7:0]          <= reg_din;
          3'd3: len_r[LEN_W-1:8]    <= reg_din[LEN_W-9:0];
          3'd4: fill_r              <= reg_din;
          3'd5: tgt_r               <= reg_din[NTGT-1:0];
          default: ;
        endcase
      end
      if (state == S_IDLE) begin
        if (abort_req_c) begin
          aborted_r <= 1'b1;
        end else if (start_req_c) begin
          cur_addr     <= start_r;
          remaining    <= len_r;
          cur_fill     <= fill_r;
          cur_tgt      <= tgt_r;
          aborted_r    <= 1'b0;
          done_r       <= empty_c;
          done_pulse_r <= empty_c;
        end
      end else begin
        if (abort_req_c) begin
          aborted_r <= 1'b1;
          done_r    <= 1'b0;
        end else if (dma_wr_c) begin
          cur_addr  <= cur_addr + ADDR_W'(1);
          remaining <= remaining - LEN_W'(1);
          if (last_c) begin
            done_r       <= 1'b1;
            done_pulse_r <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    reg_dout = 8'h00;
    case (reg_addr)
      3'd0: reg_dout = start_r[7:0];
      3'd1: reg_dout = 8'(start_r >> 8);
      3'd2: reg_dout = len_r[7:0];
      3'd3: reg_dout = 8'(len_r >> 8);
      3'd4: reg_dout = fill_r;
      3'd5: reg_dout = 8'(tgt_r);
      3'd6: reg_dout = {5'b0, aborted_r, done_r, busy};
      default: reg_dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_vram_fill_dma.sv
// Scoreboard bench for vram_fill_dma: expected fill writes queued from a plain-arithmetic model, checked by a negedge monitor.
module tb_vram_fill_dma;
  localparam int unsigned AW = 11;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          reg_cs = 1'b0, reg_wr = 1'b0;
  logic [2:0]    reg_addr = 3'd0;
  logic [7:0]    reg_din = 8'h00;
  logic [7:0]    reg_dout;
  logic [AW-1:0] cpu_ram_addr = '0;
  logic [7:0]    cpu_ram_data = 8'h00;
  logic [2:0]    cpu_ram_wr = 3'b000;
  logic          vblank = 1'b1;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic [2:0]    ram_wr;
  logic          busy, done_pulse;

  vram_fill_dma dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .reg_cs(reg_cs), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_din(reg_din), .reg_dout(reg_dout),
    .cpu_ram_addr(cpu_ram_addr), .cpu_ram_data(cpu_ram_data), .cpu_ram_wr(cpu_ram_wr),
    .vblank(vblank), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wr(ram_wr),
    .busy(busy), .done_pulse(done_pulse)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = -1;
  int fill_pops = 0;
  logic [AW+10:0] fill_q[$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: CPU traffic must pass straight through; any other write must be the next queued fill write
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (cpu_ram_wr != 3'b000) begin
        check("cpu_passthrough", 32'({ram_addr, ram_data, ram_wr}),
              32'({cpu_ram_addr, cpu_ram_data, cpu_ram_wr}));
      end else if (ram_wr != 3'b000) begin
        if (fill_q.size() == 0) begin
          check("unexpected_write", 32'({ram_addr, ram_data, ram_wr}), 32'h0);
        end else begin
          check("fill_write", 32'({ram_addr, ram_data, ram_wr}), 32'(fill_q.pop_front()));
          fill_pops++;
        end
      end
      if (done_pulse) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk_sys); #1;
    reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_din = d;
    @(posedge clk_sys); #1;
    reg_cs = 1'b0; reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
    reg_addr = a; #1;
    d = reg_dout;
  endtask

  task automatic program_regs(input int st, input int len, input int f, input int t);
    reg_write(3'd0, 8'(st));
    reg_write(3'd1, 8'(st >> 8));
    reg_write(3'd2, 8'(len));
    reg_write(3'd3, 8'(len >> 8));
    reg_write(3'd4, 8'(f));
    reg_write(3'd5, 8'(t));
  endtask

  task automatic push_fill(input int st, input int len, input int f, input int t);
    for (int i = 0; i < len; i++) fill_q.push_back({AW'(st + i), 8'(f), 3'(t)});
  endtask

  task automatic wait_done(input int prev, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt == prev && n < budget) begin
      @(posedge clk_sys); n++;
    end
    #1;
    if (done_cnt == prev) check({name, "_timeout"}, 32'(n), 32'(budget + 1));
  endtask

  // mode 0: no CPU traffic, 1: CPU chram write in second fill cycle, 2: random CPU traffic
  task automatic run_fill(input int st, input int len, input int f, input int t, input int mode);
    bit pat[256];
    int left, exp_off, prev, s;
    logic [7:0] rd;
    for (int i = 0; i < 256; i++) pat[i] = (mode == 2) ? ($urandom_range(3) == 0) : 1'b0;
    if (mode == 1) pat[1] = 1'b1;
    program_regs(st, len, f, t);
    if (t == 0) left = 0; else left = len;
    if (left > 0) push_fill(st, len, f, t);
    exp_off = 0;
    while (left > 0) begin
      if (!(exp_off < 256 && pat[exp_off])) left--;
      exp_off++;
    end
    prev = done_cnt;
    reg_write(3'd6, 8'h01);
    s = cyc;
    for (int off = 0; off <= exp_off + 1; off++) begin
      if (off > 0) begin @(posedge clk_sys); #1; end
      if (off < 256 && pat[off] && off < exp_off) begin
        cpu_ram_wr   = (mode == 1) ? 3'b001 : 3'($urandom_range(1, 7));
        cpu_ram_addr = (mode == 1) ? AW'(12'h055) : AW'($urandom);
        cpu_ram_data = (mode == 1) ? 8'hAA : 8'($urandom);
      end else begin
        cpu_ram_wr = 3'b000;
      end
      if (off == 0) check("busy_after_start", 32'(busy), 32'((t != 0 && len != 0) ? 1 : 0));
    end
    cpu_ram_wr = 3'b000;
    check("done_count", 32'(done_cnt), 32'(prev + 1));
    check("done_cycle", 32'(last_done_cyc), 32'(s + exp_off));
    check("queue_drained", 32'(fill_q.size()), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    reg_read(3'd6, rd);
    check("ctrl_after_done", 32'(rd), 32'h02);
  endtask

  initial begin
    logic [7:0] rd, v;
    int prev, s, p0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ctrl", 32'(reg_dout), 32'd0);
    reset_n = 1'b1;

    // Register readback with unused bits masked off
    for (int a = 0; a < 8; a++) begin
      v = 8'($urandom);
      reg_write(3'(a), (a == 6) ? 8'h00 : v);
      reg_read(3'(a), rd);
      case (a)
        1: check("rd_start_hi", 32'(rd), 32'(v & 8'h07));
        3: check("rd_len_hi", 32'(rd), 32'(v & 8'h0F));
        5: check("rd_tgt", 32'(rd), 32'(v & 8'h07));
        6: check("rd_ctrl_idle", 32'(rd), 32'h00);
        7: check("rd_reg7", 32'(rd), 32'h00);
        default: check("rd_reg", 32'(rd), 32'(v));
      endcase
    end

    run_fill(12'h7FE, 4, 8'h41, 1, 0);
    run_fill(12'h123, 0, 8'h55, 1, 0);
    run_fill(12'h100, 3, 8'h07, 6, 1);
    run_fill(12'h010, 5, 8'h22, 0, 0);
    run_fill(12'h7F0, 2050, 8'hC3, 7, 0);
    for (int i = 0; i < 10; i++)
      run_fill(int'($urandom_range(0, 2047)), int'($urandom_range(1, 40)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 7)), 2);

    // Register writes and a second start during RUN must not disturb the fill in progress
    program_regs(12'h200, 6, 8'h5A, 5);
    push_fill(12'h200, 6, 8'h5A, 5);
    prev = done_cnt;
    reg_write(3'd6, 8'h01);
    s = cyc;
    reg_write(3'd4, 8'h99);
    reg_write(3'd0, 8'h33);
    reg_write(3'd6, 8'h01);
    wait_done(prev, 20, "midrun");
    check("midrun_done_cycle", 32'(last_done_cyc), 32'(s + 6));
    repeat (3) @(posedge clk_sys); #1;
    check("midrun_queue", 32'(fill_q.size()), 32'd0);
    reg_read(3'd4, rd);
    check("midrun_fill_reg", 32'(rd), 32'h99);
    reg_read(3'd0, rd);
    check("midrun_start_reg", 32'(rd), 32'h33);

    // Start and abort together in IDLE only sets aborted
    prev = done_cnt;
    reg_write(3'd6, 8'h03);
    repeat (2) @(posedge clk_sys); #1;
    reg_read(3'd6, rd);
    check("idle_abort_ctrl", 32'(rd), 32'h06);
    check("idle_abort_no_pulse", 32'(done_cnt), 32'(prev));

    // Abort after 10 writes
    v = 8'($urandom);
    s = int'($urandom_range(0, 2047));
    program_regs(s, 100, v, 3);
    push_fill(s, 100, v, 3);
    prev = done_cnt;
    p0 = fill_pops;
    reg_write(3'd6, 8'h01);
    repeat (9) @(posedge clk_sys);
    reg_write(3'd6, 8'h02);
    repeat (4) @(posedge clk_sys); #1;
    check("abort_write_count", 32'((fill_pops - p0 == 10) || (fill_pops - p0 == 11)), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_no_pulse", 32'(done_cnt), 32'(prev));
    reg_read(3'd6, rd);
    check("abort_ctrl", 32'(rd), 32'h04);
    fill_q.delete();

`ifdef VRAM_FILL_VBLANK_ONLY_EN
    vblank = 1'b0;
    program_regs(12'h040, 8, 8'h11, 2);
    push_fill(12'h040, 8, 8'h11, 2);
    prev = done_cnt;
    p0 = fill_pops;
    reg_write(3'd6, 8'h01);
    repeat (19) @(posedge clk_sys); #1;
    check("vblank_hold_writes", 32'(fill_pops - p0), 32'd0);
    vblank = 1'b1;
    s = cyc;
    wait_done(prev, 30, "vblank");
    check("vblank_done_cycle", 32'(last_done_cyc), 32'(s + 8));
    check("vblank_queue", 32'(fill_q.size()), 32'd0);
`endif

    // Asynchronous reset in the middle of a 50-byte fill
    program_regs(12'h300, 50, 8'h77, 7);
    push_fill(12'h300, 50, 8'h77, 7);
    reg_write(3'd6, 8'h01);
    repeat (5) @(posedge clk_sys);
    #3 reset_n = 1'b0;
    #1;
    check("rst_ram_wr", 32'(ram_wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_pulse", 32'(done_pulse), 32'd0);
    for (int a = 0; a < 8; a++) begin
      reg_read(3'(a), rd);
      check("rst_reg", 32'(rd), 32'd0);
    end
    fill_q.delete();
    @(posedge clk_sys); #1 reset_n = 1'b1;
    repeat (5) @(posedge clk_sys); #1;
    check("rst_stays_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
